sc_pe_scheduler: RTL and testbench

Sequencer for the successive-cancellation polar decoder datapath. Walks the SC decoding tree for one N-bit codeword and issues f/g operations, one batch of up to P LLR pairs per cycle, to the shared array of P processing elements. At each leaf it hands off to the hard-decision/frozen-bit logic and waits for the decided bit before resuming. LLR storage, partial sums and the PEs themselves are outside this block; it produces only control.

---
 rtl/sc_pe_scheduler.sv | 132 +++++++++++++
 tb/tb_sc_pe_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_pe_scheduler.sv
// Control sequencer for an SC polar decoder: walks the decoding tree, issues
// f/g batches to the shared PE array and performs the per-leaf bit handshake.
module sc_pe_scheduler #(
  parameter int LOG2N = 9,
  parameter int LOG2P = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pe_ready,
  input  logic             u_valid,
  output logic             busy,
  output logic             pe_valid,
  output logic             pe_control,
  output logic [3:0]       pe_stage,
  output logic [LOG2N-1:0] pe_batch,
  output logic             leaf_valid,
  output logic [LOG2N-1:0] leaf_idx,
  output logic             done
);

  typedef logic [LOG2N-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, CALC, LEAF, DONE} state_t;

  localparam idx_t LAST_BIT = idx_t'((1 << LOG2N) - 1);

  state_t     state_q;
  idx_t       bit_q;
  logic [3:0] stage_q;
  idx_t       batch_q;
  logic       control_q;
  logic       busy_q;
  logic       pe_valid_q;
  logic       leaf_valid_q;
  logic       done_q;
  idx_t       last_batch_d;
  idx_t       next_bit_d;

  // Lowest set bit of v; v is never zero on any path that uses it.
  function automatic logic [3:0] tz(input idx_t v);
    tz = 4'd0;
    for (int k = LOG2N - 1; k >= 0; k--) begin
      if (v[k]) tz = 4'(k);
    end
  endfunction

  always_comb begin
    last_batch_d = '0;
    if (int'(stage_q) >= LOG2P) begin
      last_batch_d = (idx_t'(1) << (int'(stage_q) - LOG2P)) - idx_t'(1);
    end
    next_bit_d = bit_q + idx_t'(1);
  end

  // NOTE: one clocked block owns state and every output register, so each
  // output changes exactly on the edge that changes the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_q        <= '0;
      stage_q      <= '0;
      batch_q      <= '0;
      control_q    <= 1'b0;
      busy_q       <= 1'b0;
      pe_valid_q   <= 1'b0;
      leaf_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bit_q      <= '0;
            stage_q    <= 4'(LOG2N - 1);
            control_q  <= 1'b0;
            batch_q    <= '0;
            busy_q     <= 1'b1;
            pe_valid_q <= 1'b1;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (pe_ready) begin
            if (batch_q != last_batch_d) begin
              batch_q <= batch_q + idx_t'(1);
            end else if (stage_q != 4'd0) begin
              stage_q   <= stage_q - 4'd1;
              control_q <= 1'b0;
              batch_q   <= '0;
            end else begin
              pe_valid_q   <= 1'b0;
              leaf_valid_q <= 1'b1;
              state_q      <= LEAF;
            end
          end
        end
        LEAF: begin
          if (u_valid) begin
            leaf_valid_q <= 1'b0;
            if (bit_q == LAST_BIT) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              // Next bit re-enters the tree with a g at its trailing-zero stage.
              bit_q      <= next_bit_d;
              stage_q    <= tz(next_bit_d);
              control_q  <= 1'b1;
              batch_q    <= '0;
              pe_valid_q <= 1'b1;
              state_q    <= CALC;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign pe_valid   = pe_valid_q;
  assign pe_control = control_q;
  assign pe_stage   = stage_q;
  assign pe_batch   = batch_q;
  assign leaf_valid = leaf_valid_q;
  assign leaf_idx   = bit_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sc_pe_scheduler.sv
// Bench for sc_pe_scheduler: two instances (N=8 with P=4 and P=2) checked
// cycle by cycle against an expected event list built from the tree walk rules.
module tb_sc_pe_scheduler;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start      [2];
  logic             pe_ready   [2];
  logic             u_valid    [2];
  logic             busy       [2];
  logic             pe_valid   [2];
  logic             pe_control [2];
  logic [3:0]       pe_stage   [2];
  logic [LOG2N-1:0] pe_batch   [2];
  logic             leaf_valid [2];
  logic [LOG2N-1:0] leaf_idx   [2];
  logic             done       [2];

  // Instance 0: LOG2P=2 (P=4); instance 1: LOG2P=1 (P=2).
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sc_pe_scheduler #(.LOG2N(LOG2N), .LOG2P(2 - g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .pe_ready  (pe_ready[g]),
      .u_valid   (u_valid[g]),
      .busy      (busy[g]),
      .pe_valid  (pe_valid[g]),
      .pe_control(pe_control[g]),
      .pe_stage  (pe_stage[g]),
      .pe_batch  (pe_batch[g]),
      .leaf_valid(leaf_valid[g]),
      .leaf_idx  (leaf_idx[g]),
      .done      (done[g])
    );
  end

  typedef struct {
    bit is_leaf;
    bit ctrl;
    int stage;
    int batch;
    int bitn;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  function automatic int model_tz(input int v);
    int t = 0;
    while (((v >> t) & 1) == 0) t++;
    return t;
  endfunction

  // Expected schedule: bit 0 runs f from the root down; bit i>0 runs g at
  // tz(i) then f down to stage 0; every stage expands into its batches.
  task automatic build(input int log2p);
    int first, nb;
    ev_t e;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      first = (i == 0) ? LOG2N - 1 : model_tz(i);
      for (int s = first; s >= 0; s--) begin
        nb = (s >= log2p) ? (1 << (s - log2p)) : 1;
        for (int b = 0; b < nb; b++) begin
          e.is_leaf = 1'b0;
          e.ctrl    = (i != 0) && (s == first);
          e.stage   = s;
          e.batch   = b;
          e.bitn    = i;
          exp_q.push_back(e);
        end
      end
      e.is_leaf = 1'b1;
      e.ctrl    = 1'b0;
      e.stage   = 0;
      e.batch   = 0;
      e.bitn    = i;
      exp_q.push_back(e);
    end
  endtask

  // mode: 0 plain, 1 backpressure in root stage, 2 stall at leaf 3,
  //       3 reset at bit 5, 4 spurious start/u_valid, 5 random stalls
  task automatic run_decode(input int d, input int mode);
    int          cyc, ops, hold, wait_l;
    bit          fin;
    ev_t         e;
    logic [15:0] act, expv;
    build(2 - d);
    ops = 0; hold = 0; wait_l = 0; fin = 1'b0;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 0;
    while (!fin) begin
      pe_ready[d] = 1'b0;
      u_valid[d]  = 1'b0;
      start[d]    = 1'b0;
      if (cyc > 400) begin
        vectors++; miscompares++;
        $display("FAIL timeout d%0d mode%0d: got no done after %0d cycles, required done", d, mode, cyc);
        fin = 1'b1;
      end else if (exp_q.size() == 0) begin
        act  = 16'({busy[d], pe_valid[d], leaf_valid[d], done[d]});
        expv = 16'b0001;
        vectors++;
        if (act !== expv) begin
          miscompares++;
          $display("FAIL done_cycle d%0d mode%0d: got %h required %h", d, mode, act, expv);
        end
        if (mode == 0 && d == 0) begin
          vectors++;
          if (cyc !== 22) begin
            miscompares++;
            $display("FAIL done_latency d%0d: got %0d required 22", d, cyc);
          end
        end
        if (mode != 3) begin
          vectors++;
          if (ops !== ((d == 0) ? 14 : 16)) begin
            miscompares++;
            $display("FAIL op_count d%0d mode%0d: got %0d required %0d", d, mode, ops, (d == 0) ? 14 : 16);
          end
        end
        if (mode == 4) start[d] = 1'b1;
        fin = 1'b1;
      end else begin
        e = exp_q[0];
        if (!e.is_leaf && mode == 3 && e.bitn == 5) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          act = 16'({busy[d], pe_valid[d], pe_control[d], pe_stage[d], pe_batch[d],
                     leaf_valid[d], leaf_idx[d], done[d]});
          vectors++;
          if (act !== 16'h0) begin
            miscompares++;
            $display("FAIL abort_clear d%0d: got %h required 0000", d, act);
          end
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            act = 16'({busy[d], pe_valid[d], leaf_valid[d], done[d]});
            vectors++;
            if (act !== 16'h0) begin
              miscompares++;
              $display("FAIL abort_quiet d%0d cycle%0d: got %h required 0000", d, k, act);
            end
          end
          fin = 1'b1;
        end else if (!e.is_leaf) begin
          act  = 16'({busy[d], pe_valid[d], leaf_valid[d], done[d], pe_control[d], pe_stage[d], pe_batch[d]});
          expv = 16'({1'b1, 1'b1, 1'b0, 1'b0, e.ctrl, 4'(e.stage), 3'(e.batch)});
          vectors++;
          if (act !== expv) begin
            miscompares++;
            $display("FAIL op d%0d mode%0d bit%0d: got %h required %h", d, mode, e.bitn, act, expv);
          end
          pe_ready[d] = (mode == 5) ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (mode == 1 && e.bitn == 0 && e.stage == LOG2N - 1 && e.batch == 1 && hold < 3) begin
            pe_ready[d] = 1'b0;
            hold++;
          end
          if (mode == 4) begin
            u_valid[d] = 1'($urandom_range(0, 1));
            start[d]   = ($urandom_range(0, 3) == 0);
          end
          if (pe_valid[d] && pe_ready[d]) ops++;
          if (pe_ready[d]) void'(exp_q.pop_front());
        end else begin
          act  = 16'({busy[d], pe_valid[d], leaf_valid[d], done[d], leaf_idx[d]});
          expv = 16'({1'b1, 1'b0, 1'b1, 1'b0, 3'(e.bitn)});
          vectors++;
          if (act !== expv) begin
            miscompares++;
            $display("FAIL leaf d%0d mode%0d bit%0d: got %h required %h", d, mode, e.bitn, act, expv);
          end
          u_valid[d] = (mode == 5) ? ($urandom_range(0, 2) == 0) : 1'b1;
          if (mode == 2 && e.bitn == 3 && wait_l < 5) begin
            u_valid[d] = 1'b0;
            wait_l++;
          end
          if (mode == 4 || mode == 5) pe_ready[d] = 1'($urandom_range(0, 1));
          if (mode == 4) start[d] = ($urandom_range(0, 3) == 0);
          if (u_valid[d]) void'(exp_q.pop_front());
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (mode == 4) begin
      @(negedge clk);
      start[d] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        act = 16'({busy[d], pe_valid[d]});
        vectors++;
        if (act !== 16'h0) begin
          miscompares++;
          $display("FAIL start_in_done d%0d cycle%0d: got %h required 0000", d, k, act);
        end
        @(negedge clk);
      end
    end
    start[d] = 1'b0; pe_ready[d] = 1'b0; u_valid[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] act;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; pe_ready[d] = 1'b0; u_valid[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      act = 16'({busy[d], pe_valid[d], pe_control[d], pe_stage[d], pe_batch[d],
                 leaf_valid[d], leaf_idx[d], done[d]});
      vectors++;
      if (act !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_state d%0d: got %h required 0000", d, act);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_walk();
    run_decode(0, 0);
    run_decode(1, 0);
  endtask

  task automatic test_backpressure();
    run_decode(1, 1);
  endtask

  task automatic test_leaf_stall();
    run_decode(0, 2);
    run_decode(1, 2);
  endtask

  task automatic test_abort();
    run_decode(0, 3);
    run_decode(0, 0);
    run_decode(1, 3);
    run_decode(1, 0);
  endtask

  task automatic test_ignored_inputs();
    run_decode(0, 4);
    run_decode(1, 4);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      run_decode(0, 5);
      run_decode(1, 5);
    end
  endtask

  initial begin
    test_reset();
    test_full_walk();
    test_backpressure();
    test_leaf_stall();
    test_abort();
    test_ignored_inputs();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
